// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, word type and rotate helper
//
// Purpose : constants and helpers shared by the SHA-256 message-schedule units.
// Contents: SIG0_R1/SIG0_R2/SIG0_S small-sigma-0 amounts, word_t, rotr().
package sha256_pkg;

   localparam int SIG0_R1 = 7;
   localparam int SIG0_R2 = 18;
   localparam int SIG0_S  = 3;

   typedef logic [31:0] word_t;

   // Rotate right by a constant amount in 1..31.
   function automatic word_t rotr(input word_t v, input int n);
      return (v >> n) | (v << (32 - n));
   endfunction

endpackage

// File: rtl/p_0_sigma_comb.sv
// rtl/p_0_sigma_comb.sv - combinational small-sigma-0 term generator
//
// Purpose : produces the three bitwise terms of sigma0(x); their XOR is sigma0(x).
//           The terms are exposed separately so the two-stage build can register
//           them before the XOR.
// Ports   : i_x      in  32  input word
//           o_rot_a  out 32  ROTR7(i_x)
//           o_rot_b  out 32  ROTR18(i_x)
//           o_shr    out 32  SHR3(i_x)
module p_0_sigma_comb
   import sha256_pkg::*;
(
   input  logic [31:0] i_x,
   output logic [31:0] o_rot_a,
   output logic [31:0] o_rot_b,
   output logic [31:0] o_shr
);

   assign o_rot_a = rotr(i_x, SIG0_R1);
   assign o_rot_b = rotr(i_x, SIG0_R2);
   assign o_shr   = i_x >> SIG0_S;

endmodule

// File: rtl/p_0.sv
// rtl/p_0.sv - registered SHA-256 small-sigma-0 unit for W[t] expansion
//
// Purpose : p0 = ROTR7(x) ^ ROTR18(x) ^ SHR3(x), presented from a register,
//           one word per clock, no backpressure.
// Build   : macro P_0_PIPE2_EN adds a register stage holding the three terms
//           (latency 2); without it the unit has latency 1.
// Ports   : clk        in  1   clock, rising edge
//           rst        in  1   synchronous active-high reset
//           x          in  32  input word W[t-15]
//           in_valid   in  1   qualifies x
//           p0         out 32  registered sigma0(x); holds when no new result
//           out_valid  out 1   p0 carries a result for a qualified input
module p_0
   import sha256_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x,
   input  logic        in_valid,
   output logic [31:0] p0,
   output logic        out_valid
);

   logic [31:0] w_rot_a;
   logic [31:0] w_rot_b;
   logic [31:0] w_shr;

   logic [31:0] r_p0;
   logic        r_out_valid;

   p_0_sigma_comb u_sigma (
      .i_x     (x),
      .o_rot_a (w_rot_a),
      .o_rot_b (w_rot_b),
      .o_shr   (w_shr)
   );

`ifdef P_0_PIPE2_EN
   logic [31:0] r_rot_a;
   logic [31:0] r_rot_b;
   logic [31:0] r_shr;
   logic        r_s1_valid;

   // Stage 1: capture the raw terms; the valid bit decides whether stage 2 uses them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rot_a    <= '0;
         r_rot_b    <= '0;
         r_shr      <= '0;
         r_s1_valid <= 1'b0;
      end else begin
         r_rot_a    <= w_rot_a;
         r_rot_b    <= w_rot_b;
         r_shr      <= w_shr;
         r_s1_valid <= in_valid;
      end
   end

   // Stage 2: XOR the registered terms; p0 holds while no new result arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p0        <= '0;
         r_out_valid <= 1'b0;
      end else if (r_s1_valid) begin
         r_p0        <= r_rot_a ^ r_rot_b ^ r_shr;
         r_out_valid <= 1'b1;
      end else begin
         r_out_valid <= 1'b0;
      end
   end
`else
   logic [31:0] w_f;

   assign w_f = w_rot_a ^ w_rot_b ^ w_shr;

   // Single stage; p0 holds while no qualified input arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p0        <= '0;
         r_out_valid <= 1'b0;
      end else if (in_valid) begin
         r_p0        <= w_f;
         r_out_valid <= 1'b1;
      end else begin
         r_out_valid <= 1'b0;
      end
   end
`endif

   assign p0        = r_p0;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_p_0.sv
// tb/tb_p_0.sv - self-checking bench for p_0 (both latency builds)
module tb_p_0;

`ifdef P_0_PIPE2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] x;
   logic        in_valid;
   logic [31:0] p0;
   logic        out_valid;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: last two edges seen (index 0 = most recent).
   logic        h_rst [2];
   logic        h_vld [2];
   logic [31:0] h_f   [2];
   logic [31:0] m_p0;
   logic        m_valid;

   logic [31:0] got_q [$];

   p_0 dut (
      .clk       (clk),
      .rst       (rst),
      .x         (x),
      .in_valid  (in_valid),
      .p0        (p0),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // sigma0 from its definition, one output bit at a time.
   function automatic logic [31:0] ref_sigma0(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[(i + 7) % 32] ^ v[(i + 18) % 32] ^ ((i + 3 < 32) ? v[(i + 3) % 32] : 1'b0);
      end
      return r;
   endfunction

   // Model update for one rising edge: a result emerges LAT edges after its input
   // unless a reset edge falls inside that window; reset clears p0, otherwise p0 holds.
   task automatic model_edge(input logic r, input logic v, input logic [31:0] xv);
      logic vis;
      logic [31:0] f;
      h_rst[1] = h_rst[0]; h_vld[1] = h_vld[0]; h_f[1] = h_f[0];
      h_rst[0] = r;        h_vld[0] = v;        h_f[0] = ref_sigma0(xv);
      if (LAT == 1) begin
         vis = h_vld[0] && !h_rst[0];
         f   = h_f[0];
      end else begin
         vis = h_vld[1] && !h_rst[1] && !h_rst[0];
         f   = h_f[1];
      end
      m_valid = vis;
      if (h_rst[0])  m_p0 = '0;
      else if (vis)  m_p0 = f;
   endtask

   task automatic step(input logic r, input logic v, input logic [31:0] xv, input string tag);
      rst = r; in_valid = v; x = xv;
      @(posedge clk);
      model_edge(r, v, xv);
      #1;
      check({tag, ".p0"}, p0, m_p0);
      check({tag, ".vld"}, {31'd0, out_valid}, {31'd0, m_valid});
      if (out_valid) got_q.push_back(p0);
   endtask

   initial begin
      logic [31:0] vec [4];
      h_rst[0] = 1'b1; h_rst[1] = 1'b1;
      h_vld[0] = 1'b0; h_vld[1] = 1'b0;
      h_f[0] = '0;     h_f[1] = '0;
      m_p0 = '0; m_valid = 1'b0;
      rst = 1'b1; in_valid = 1'b0; x = '0;

      // Reset with a live input present: outputs stay at zero throughout.
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 32'hFFFF_FFFF, "reset");
         check("reset.p0_zero", p0, 32'h0);
         check("reset.vld_zero", {31'd0, out_valid}, 32'h0);
      end

      // Nominal: value present for two edges; settled after the second edge in either build.
      step(1'b0, 1'b1, 32'h0000_FFFF, "nom1");
      step(1'b0, 1'b1, 32'h0000_FFFF, "nom2");
      check("nom.p0_const", p0, 32'hC1FF_DE00);
      check("nom.vld_const", {31'd0, out_valid}, 32'h1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, "drain");

      // Back-to-back vectors: results appear in order at one per clock.
      vec[0] = 32'h0000_0000; vec[1] = 32'h0000_0001;
      vec[2] = 32'h8000_0000; vec[3] = 32'hFFFF_FFFF;
      got_q.delete();
      foreach (vec[i]) step(1'b0, 1'b1, vec[i], "stream");
      for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 32'h0, "stream_tail");
      check("stream.count", got_q.size(), 32'd4);
      if (got_q.size() == 4) begin
         check("stream.v0", got_q[0], 32'h0000_0000);
         check("stream.v1", got_q[1], 32'h0200_4000);
         check("stream.v2", got_q[2], 32'h1100_2000);
         check("stream.v3", got_q[3], 32'h1FFF_FFFF);
      end

      // Hold: x=1 then idle; value sticks, valid drops.
      step(1'b0, 1'b1, 32'h0000_0001, "hold_in");
      for (int i = 0; i < LAT + 2; i++) step(1'b0, 1'b0, $urandom, "hold");
      check("hold.p0_const", p0, 32'h0200_4000);
      check("hold.vld_const", {31'd0, out_valid}, 32'h0);

      // Reset priority over a valid input, with a valid input in flight before it.
      step(1'b0, 1'b1, 32'h8000_0000, "rstpri_pre");
      step(1'b1, 1'b1, 32'h0000_FFFF, "rstpri");
      check("rstpri.p0_zero", p0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'h0, "rstpri_after");
         check("rstpri.no_stale", {31'd0, out_valid}, 32'h0);
         check("rstpri.p0_still0", p0, 32'h0);
      end

      // Random stream with occasional resets.
      for (int i = 0; i < 10000; i++) begin
         step(($urandom_range(63) == 0), $urandom_range(1), $urandom, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
